fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// Optional beat statistics are enabled with the FIFO_ARB_STATS_EN macro.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // Wide enough to hold the value BURST itself, so the counter never wraps.
    function automatic int beat_cnt_width(input int burst);
        return (burst < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit
// scanning upward from (last+1) mod NREQ with wrap-around.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic            o_found,
    output logic [IDW-1:0]  o_idx
);

    // NOTE: every output gets a default before the loop, otherwise a path
    // that assigns nothing would infer a latch.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!o_found && i_req[(int'(i_last) + off) % NREQ]) begin
                o_found = 1'b1;
                o_idx   = IDW'((int'(i_last) + off) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the async FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]   stat_beats
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = beat_cnt_width(BURST);
    localparam logic [BW-1:0] BURST_C = BW'(BURST);

    state_t          r_state;
    logic [IDW-1:0]  r_grant;
    logic [IDW-1:0]  r_last;
    logic [BW-1:0]   r_beats;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic            w_in_grant;
    logic            w_gnt_valid;
    logic            w_xfer;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_in_grant  = (r_state == GRANT);
    assign w_gnt_valid = req_valid[r_grant];
    assign w_xfer      = w_in_grant && w_gnt_valid && !fifo_full;

    // Outputs decode straight from the state, so an async reset drops them at once.
    always_comb begin
        req_ready = '0;
        fifo_din  = '0;
        if (w_in_grant) begin
            req_ready[r_grant] = !fifo_full;
            fifo_din           = req_data[int'(r_grant)*WIDTH +: WIDTH];
        end
    end

    assign fifo_wr_en = w_xfer;
    assign busy       = w_in_grant;
    assign grant_id   = r_grant;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDW'(NREQ - 1);
            r_beats <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_beats <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_gnt_valid) begin
                        r_state <= IDLE;
                    end else if (!fifo_full) begin
                        r_beats <= r_beats + BW'(1);
                        if (r_beats + BW'(1) == BURST_C) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];

    // NOTE: the counter array is reset explicitly because software reads it
    // as an absolute count; plain storage arrays normally need no reset.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_xfer && (r_stat[r_grant] != {STAT_W{1'b1}})) begin
            r_stat[r_grant] <= r_stat[r_grant] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_beats[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                    wr_clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [WIDTH-1:0]        fifo_din;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*16-1:0]      stat_beats;
`endif

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats (stat_beats)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, how many beats it has used,
    // and who was granted last.
    bit              m_granted;
    int              m_owner;
    int              m_gid;
    int              m_last;
    int              m_cnt;
    int              m_stat [NREQ];
    int              seq    [NREQ];
    logic [NREQ-1:0] m_acc;

    int   obs_wr;
    bit   obs_prev_busy;
    int   grant_log [$];

    function automatic logic [WIDTH-1:0] tag_of(input int i);
        return WIDTH'((i << 4) | (seq[i] & 15));
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = tag_of(i);
        end
    endtask

    task automatic model_reset();
        m_granted = 1'b0;
        m_owner   = 0;
        m_gid     = 0;
        m_last    = NREQ - 1;
        m_cnt     = 0;
        m_acc     = '0;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic full);
        logic [NREQ-1:0] e_ready;
        logic            e_wr;
        logic [WIDTH-1:0] e_din;
        @(negedge wr_clk);
        req_valid = v;
        fifo_full = full;
        drive_data();
        #1;
        e_ready = '0;
        e_wr    = 1'b0;
        e_din   = '0;
        if (m_granted) begin
            e_ready[m_owner] = !full;
            e_wr             = v[m_owner] && !full;
            e_din            = tag_of(m_owner);
        end
        check("busy",     64'(busy),       64'(m_granted));
        check("grant_id", 64'(grant_id),   64'(m_gid));
        check("ready",    64'(req_ready),  64'(e_ready));
        check("wr_en",    64'(fifo_wr_en), 64'(e_wr));
        check("din",      64'(fifo_din),   64'(e_din));
`ifdef FIFO_ARB_STATS_EN
        begin
            logic [NREQ*16-1:0] e_stat;
            for (int i = 0; i < NREQ; i++) e_stat[i*16 +: 16] = 16'(m_stat[i]);
            check("stat_beats", 64'(stat_beats), 64'(e_stat));
        end
`endif
        obs_wr += int'(fifo_wr_en);
        if (busy && !obs_prev_busy) grant_log.push_back(int'(grant_id));
        obs_prev_busy = busy;

        @(posedge wr_clk);
        m_acc = '0;
        if (!m_granted) begin
            for (int off = 1; off <= NREQ; off++) begin
                int idx;
                idx = (m_last + off) % NREQ;
                if (v[idx]) begin
                    m_granted = 1'b1;
                    m_owner   = idx;
                    m_gid     = idx;
                    m_last    = idx;
                    m_cnt     = 0;
                    break;
                end
            end
        end else if (!v[m_owner]) begin
            m_granted = 1'b0;
        end else if (!full) begin
            m_cnt++;
            m_acc[m_owner] = 1'b1;
            seq[m_owner]++;
            if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
            if (m_cnt == BURST) m_granted = 1'b0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        int n;

        for (int i = 0; i < NREQ; i++) seq[i] = i * 3;
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        drive_data();
        model_reset();
        obs_prev_busy = 1'b0;
        repeat (2) @(negedge wr_clk);
        #2 rst = 1'b0;

        // Idle after reset.
        repeat (10) step('0, 1'b0);

        // All requesters continuously valid: 16 beats in 20 cycles, order 0..3.
        obs_wr = 0;
        grant_log.delete();
        repeat (20) step('1, 1'b0);
        check("beats_in_20_cycles", 64'(obs_wr), 64'd16);
        check("grant_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("grant_order", 64'(grant_log[i]), 64'(i));
        end
        repeat (3) step('0, 1'b0);

        // Requester 2 alone for 3 beats, then valid drops.
        obs_wr = 0;
        n = 0;
        while (seq[2] < 2 * 3 + 3 + 4 && n < 20) begin
            if (obs_wr == 3) break;
            step(4'b0100, 1'b0);
            n++;
        end
        check("req2_beats", 64'(obs_wr), 64'd3);
        repeat (3) step('0, 1'b0);
        check("req2_grant_kept", 64'(grant_id), 64'd2);
        obs_wr = 0;
        n = 0;
        while (obs_wr == 0 && n < 10) begin
            step(4'b0010, 1'b0);
            n++;
        end
        check("req1_latency", 64'(n), 64'd2);
        repeat (6) step('0, 1'b0);

        // FIFO full for 5 cycles during beat 2 of a burst.
        obs_wr = 0;
        n = 0;
        while (!(m_granted && m_cnt == 1) && n < 20) begin
            step(4'b0001, 1'b0);
            n++;
        end
        check("stall_setup", 64'(n < 20), 64'd1);
        repeat (5) step(4'b0001, 1'b1);
        n = 0;
        while (m_granted && n < 20) begin
            step(4'b0001, 1'b0);
            n++;
        end
        check("stall_burst_beats", 64'(obs_wr), 64'd4);
        repeat (3) step('0, 1'b0);

        // Asynchronous reset during beat 3.
        n = 0;
        while (!(m_granted && m_cnt == 2) && n < 40) begin
            step('1, 1'b0);
            n++;
        end
        check("rst_setup", 64'(n < 40), 64'd1);
        @(negedge wr_clk);
        req_valid = '1;
        fifo_full = 1'b0;
        drive_data();
        #1 check("wr_before_rst", 64'(fifo_wr_en), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_gid",   64'(grant_id), 64'd0);
        model_reset();
        obs_prev_busy = 1'b0;
        @(posedge wr_clk);
        #2 rst = 1'b0;
        grant_log.delete();
        obs_wr = 0;
        repeat (6) step('1, 1'b0);
        check("post_rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 99), 64'd0);
        check("post_rst_beats", 64'(obs_wr), 64'd4);

        // Random traffic; valid is held until the pending beat is taken.
        rv = '0;
        repeat (500) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(rv[i] && !m_acc[i])) rv[i] = ($urandom_range(0, 3) != 0);
            end
            step(rv, $urandom_range(0, 5) == 0);
        end
        repeat (3) step('0, 1'b0);

`ifdef FIFO_ARB_STATS_EN
        // Requester 1 alone long enough to saturate its beat counter.
        n = 0;
        while (m_stat[1] < 65535 && n < 85000) begin
            step(4'b0010, 1'b0);
            n++;
        end
        repeat (20) step(4'b0010, 1'b0);
        check("stat1_saturated", 64'(stat_beats[1*16 +: 16]), 64'hFFFF);
        check("stat0_unchanged", 64'(stat_beats[0*16 +: 16]), 64'(m_stat[0]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
